// File: rtl/stepper_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_spi_pkg
//  Description : Shared types and constants for the stepper-driver SPI
//                transaction arbiter (FSM state encoding, frame width,
//                default gap and timeout lengths).
//  Revision    : 1.0 - initial release
// ============================================================================
package stepper_spi_pkg;

    // Frame width of the shared SPI master
    localparam int SPI_SIZE       = 40;
    // Idle cycles with send-enable low between frames
    localparam int DEF_GAP_CYCLES = 32;
    // Cycles from send-enable assertion to frame end before abort
    localparam int DEF_TIMEOUT    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_START   = 3'd2,
        ST_BUSY    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Grants the first set
//                request bit at or after the pointer, wrapping upward.
//                The pointer register is owned by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_valid
);

    logic [PTR_W-1:0] w_idx;

    // Scan from the pointer upward with wrap-around; first hit wins
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = PTR_W'((int'(ptr) + off) % N);
            if (!grant_valid && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_arbiter
//  Description : Shares one SPI master among N_REQ requesters. Round-robin
//                grant, one full frame per grant, frame end detected from the
//                fed-back chip-select, MISO word returned to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter
    import stepper_spi_pkg::*;
#(
    parameter int SIZE       = SPI_SIZE,
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_REQ-1:0]      req_valid_in,
    input  logic [N_REQ*SIZE-1:0] req_data_in,
    output logic [N_REQ-1:0]      req_ready_out,
    output logic [N_REQ-1:0]      resp_valid_out,
    output logic [SIZE-1:0]       resp_data_out,
    output logic                  resp_err_out,
    output logic                  busy_out,
    output logic [SIZE-1:0]       spi_data_out,
    output logic                  spi_send_enable_out,
    output logic [N_REQ-1:0]      spi_cs_select_out,
    input  logic                  spi_cs_n_in,
    input  logic [SIZE-1:0]       spi_miso_word_in
);

    localparam int c_PTR_W = (N_REQ > 1)      ? $clog2(N_REQ)      : 1;
    localparam int c_TMO_W = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 r_cs_n_q;
    logic                 r_err;
    logic [N_REQ-1:0]     r_req_ready;
    logic [N_REQ-1:0]     r_resp_valid;
    logic [SIZE-1:0]      r_resp_data;
    logic                 r_resp_err;
    logic                 r_busy;
    logic [SIZE-1:0]      r_spi_data;
    logic                 r_send_en;
    logic [N_REQ-1:0]     r_cs_select;

    logic [N_REQ-1:0]     w_grant;
    logic                 w_grant_valid;
    logic [c_PTR_W-1:0]   w_gidx;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic [SIZE-1:0]      w_sel_data;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req         (req_valid_in),
        .ptr         (r_ptr),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // Turn the one-hot grant into an index and pick the winner's MOSI word
    always_comb begin
        w_gidx     = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx     = c_PTR_W'(i);
                w_sel_data = req_data_in[i*SIZE +: SIZE];
            end
        end
    end

    assign w_next_ptr = (w_gidx == c_PTR_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;

    // Transaction sequencer: grant, settle, frame, capture, enforced gap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_tmo_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_cs_n_q     <= 1'b1;
            r_err        <= 1'b0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_spi_data   <= '0;
            r_send_en    <= 1'b0;
            r_cs_select  <= '0;
        end else begin
            r_cs_n_q     <= spi_cs_n_in;
            // Handshake pulses last exactly one cycle
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_req_ready <= w_grant;
                        r_spi_data  <= w_sel_data;
                        r_cs_select <= w_grant;
                        r_ptr       <= w_next_ptr;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Master's chip-select mux has settled; launch the frame
                    r_send_en <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= ST_START;
                end
                ST_START: begin
                    if (r_tmo_cnt == c_TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_cs_n_q && !spi_cs_n_in) begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_tmo_cnt == c_TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (!r_cs_n_q && spi_cs_n_in) begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_resp_data  <= r_err ? '0 : spi_miso_word_in;
                    r_resp_valid <= r_cs_select;
                    r_resp_err   <= r_err;
                    r_send_en    <= 1'b0;
                    r_gap_cnt    <= '0;
                    r_state      <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_cs_select <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_send_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_out       = r_req_ready;
    assign resp_valid_out      = r_resp_valid;
    assign resp_data_out       = r_resp_data;
    assign resp_err_out        = r_resp_err;
    assign busy_out            = r_busy;
    assign spi_data_out        = r_spi_data;
    assign spi_send_enable_out = r_send_en;
    assign spi_cs_select_out   = r_cs_select;

endmodule
`default_nettype wire
